// File: rtl/lc4_regfile_sb_if.sv
// Bundle of the scoreboarded register file's read, writeback, issue and control signals.
// The core drives the master side; the register file is the slave.
interface lc4_regfile_sb_if #(
  parameter int n     = 16,
  parameter int ABITS = 3,
  parameter int NPIPE = 2
);
  logic                   gwe;
  logic [NPIPE*ABITS-1:0] i_rs;
  logic [NPIPE*ABITS-1:0] i_rt;
  logic [NPIPE-1:0]       i_rs_en;
  logic [NPIPE-1:0]       i_rt_en;
  logic [NPIPE*n-1:0]     o_rs_data;
  logic [NPIPE*n-1:0]     o_rt_data;
  logic [NPIPE-1:0]       o_rs_busy;
  logic [NPIPE-1:0]       o_rt_busy;
  logic                   o_stall;
  logic [NPIPE*ABITS-1:0] i_rd;
  logic [NPIPE*n-1:0]     i_wdata;
  logic [NPIPE-1:0]       i_rd_we;
  logic [NPIPE*ABITS-1:0] i_iss_rd;
  logic [NPIPE-1:0]       i_iss_we;
  logic                   i_flush;
  logic                   o_ovf;
  logic                   o_unf;

  modport master (
    output gwe, i_rs, i_rt, i_rs_en, i_rt_en, i_rd, i_wdata, i_rd_we,
           i_iss_rd, i_iss_we, i_flush,
    input  o_rs_data, o_rt_data, o_rs_busy, o_rt_busy, o_stall, o_ovf, o_unf
  );

  modport slave (
    input  gwe, i_rs, i_rt, i_rs_en, i_rt_en, i_rd, i_wdata, i_rd_we,
           i_iss_rd, i_iss_we, i_flush,
    output o_rs_data, o_rt_data, o_rs_busy, o_rt_busy, o_stall, o_ovf, o_unf
  );
endinterface

// File: rtl/lc4_regfile_sb.sv
// Multi-pipe register file with writeback bypass and a saturating per-register
// pending-producer scoreboard that drives operand busy and pipeline stall.
module lc4_regfile_sb #(
  parameter int n     = 16,
  parameter int NREG  = 8,
  parameter int ABITS = 3,
  parameter int NPIPE = 2,
  parameter int CBITS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  lc4_regfile_sb_if.slave   bus
);
  localparam int WB = $clog2(NPIPE) + 1;
  localparam int NB = CBITS + WB;
  localparam logic signed [NB-1:0] CMAX = NB'((1 << CBITS) - 1);

  logic [n-1:0]            regs_q [NREG];
  logic [CBITS-1:0]        cnt_q  [NREG];
  logic [CBITS-1:0]        cnt_d  [NREG];
  logic                    ovf_q, unf_q;
  logic [WB-1:0]           wcnt_s [NREG];
  logic [WB-1:0]           icnt_s [NREG];
  logic                    wvld_s [NREG];
  logic [n-1:0]            wdat_s [NREG];
  logic signed [NB-1:0]    nxt_s  [NREG];
  logic                    ovf_set_s, unf_set_s;

  // Per-register writeback/issue tallies; the later (higher) pipe wins the data.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      wcnt_s[r] = '0;
      icnt_s[r] = '0;
      wvld_s[r] = 1'b0;
      wdat_s[r] = '0;
      for (int p = 0; p < NPIPE; p++) begin
        wcnt_s[r] = wcnt_s[r] + WB'(bus.i_rd_we[p] && (bus.i_rd[p*ABITS +: ABITS] == ABITS'(r)));
        icnt_s[r] = icnt_s[r] + WB'(bus.i_iss_we[p] && (bus.i_iss_rd[p*ABITS +: ABITS] == ABITS'(r)));
        wdat_s[r] = (bus.i_rd_we[p] && (bus.i_rd[p*ABITS +: ABITS] == ABITS'(r)))
                    ? bus.i_wdata[p*n +: n] : wdat_s[r];
        wvld_s[r] = wvld_s[r] | (bus.i_rd_we[p] && (bus.i_rd[p*ABITS +: ABITS] == ABITS'(r)));
      end
    end
  end

  // Read ports: bypass from this cycle's writebacks, busy if producers remain after them.
  always_comb begin
    bus.o_rs_data = '0;
    bus.o_rt_data = '0;
    bus.o_rs_busy = '0;
    bus.o_rt_busy = '0;
    bus.o_stall   = 1'b0;
    for (int p = 0; p < NPIPE; p++) begin
      bus.o_rs_data[p*n +: n] = wvld_s[bus.i_rs[p*ABITS +: ABITS]]
                                ? wdat_s[bus.i_rs[p*ABITS +: ABITS]]
                                : regs_q[bus.i_rs[p*ABITS +: ABITS]];
      bus.o_rt_data[p*n +: n] = wvld_s[bus.i_rt[p*ABITS +: ABITS]]
                                ? wdat_s[bus.i_rt[p*ABITS +: ABITS]]
                                : regs_q[bus.i_rt[p*ABITS +: ABITS]];
      bus.o_rs_busy[p] = {{WB{1'b0}}, cnt_q[bus.i_rs[p*ABITS +: ABITS]]}
                         > {{CBITS{1'b0}}, wcnt_s[bus.i_rs[p*ABITS +: ABITS]]};
      bus.o_rt_busy[p] = {{WB{1'b0}}, cnt_q[bus.i_rt[p*ABITS +: ABITS]]}
                         > {{CBITS{1'b0}}, wcnt_s[bus.i_rt[p*ABITS +: ABITS]]};
      bus.o_stall = bus.o_stall | (bus.o_rs_busy[p] & bus.i_rs_en[p])
                                | (bus.o_rt_busy[p] & bus.i_rt_en[p]);
    end
  end

  // Signed next count with saturation at both ends; the sign bit flags underflow.
  always_comb begin
    ovf_set_s = 1'b0;
    unf_set_s = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      nxt_s[r] = $signed({{WB{1'b0}}, cnt_q[r]})
               - $signed({{CBITS{1'b0}}, wcnt_s[r]})
               + $signed({{CBITS{1'b0}}, icnt_s[r]});
      cnt_d[r] = nxt_s[r][NB-1] ? {CBITS{1'b0}}
               : (nxt_s[r] > CMAX) ? {CBITS{1'b1}}
               : nxt_s[r][CBITS-1:0];
      unf_set_s = unf_set_s | nxt_s[r][NB-1];
      ovf_set_s = ovf_set_s | (!nxt_s[r][NB-1] && (nxt_s[r] > CMAX));
    end
  end

  // Stored state: data, counters and sticky flags advance only when gwe is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (bus.gwe) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= wvld_s[r] ? wdat_s[r] : regs_q[r];
        cnt_q[r]  <= bus.i_flush ? {CBITS{1'b0}} : cnt_d[r];
      end
      ovf_q <= ovf_q | (ovf_set_s & ~bus.i_flush);
      unf_q <= unf_q | (unf_set_s & ~bus.i_flush);
    end else begin
      ovf_q <= ovf_q;
      unf_q <= unf_q;
    end
  end

  assign bus.o_ovf = ovf_q;
  assign bus.o_unf = unf_q;
endmodule

// File: tb/tb_lc4_regfile_sb.sv
// Directed bench for lc4_regfile_sb: bypass, scoreboard saturation, flush,
// gwe gating and asynchronous reset, against hand-computed expectations.
module tb_lc4_regfile_sb;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  lc4_regfile_sb_if #(.n(16), .ABITS(3), .NPIPE(2)) bus ();

  lc4_regfile_sb #(.n(16), .NREG(8), .ABITS(3), .NPIPE(2), .CBITS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.gwe      = 1'b1;
    bus.i_rs     = '0;
    bus.i_rt     = '0;
    bus.i_rs_en  = '0;
    bus.i_rt_en  = '0;
    bus.i_rd     = '0;
    bus.i_wdata  = '0;
    bus.i_rd_we  = '0;
    bus.i_iss_rd = '0;
    bus.i_iss_we = '0;
    bus.i_flush  = 1'b0;
  endtask

  task automatic wb(input int p, input int r, input logic [15:0] d);
    bus.i_rd[p*3 +: 3]     = 3'(r);
    bus.i_wdata[p*16 +: 16] = d;
    bus.i_rd_we[p]         = 1'b1;
  endtask

  task automatic iss(input int p, input int r);
    bus.i_iss_rd[p*3 +: 3] = 3'(r);
    bus.i_iss_we[p]        = 1'b1;
  endtask

  task automatic rs(input int p, input int r, input logic en);
    bus.i_rs[p*3 +: 3] = 3'(r);
    bus.i_rs_en[p]     = en;
  endtask

  task automatic rt(input int p, input int r, input logic en);
    bus.i_rt[p*3 +: 3] = 3'(r);
    bus.i_rt_en[p]     = en;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    idle();
    rs(0, 0, 1'b1);
    #3;
    chk("rst_data",  32'(bus.o_rs_data[15:0]), 32'h0);
    chk("rst_busy",  32'(bus.o_rs_busy[0]), 32'h0);
    chk("rst_stall", 32'(bus.o_stall), 32'h0);
    chk("rst_ovf",   32'(bus.o_ovf), 32'h0);
    chk("rst_unf",   32'(bus.o_unf), 32'h0);
    #9;
    rst_n = 1'b1;
    tick();

    // Dual write to r3: pipe1 wins both bypass and storage.
    idle();
    wb(0, 3, 16'h1111);
    wb(1, 3, 16'h2222);
    rs(0, 3, 1'b1);
    rt(1, 3, 1'b1);
    #1;
    chk("dual_byp_rs", 32'(bus.o_rs_data[15:0]), 32'h2222);
    chk("dual_byp_rt", 32'(bus.o_rt_data[31:16]), 32'h2222);
    chk("dual_busy",   32'(bus.o_rs_busy[0]), 32'h0);
    tick();
    idle();
    rs(0, 3, 1'b0);
    #1;
    chk("dual_stored", 32'(bus.o_rs_data[15:0]), 32'h2222);
    chk("dual_unf",    32'(bus.o_unf), 32'h1);
    chk("dual_ovf",    32'(bus.o_ovf), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rst1_r3",  32'(bus.o_rs_data[15:0]), 32'h0);
    chk("rst1_unf", 32'(bus.o_unf), 32'h0);
    rst_n = 1'b1;
    tick();

    // Issue r5, then writeback it.
    idle();
    iss(0, 5);
    tick();
    idle();
    rs(0, 5, 1'b1);
    #1;
    chk("iss_busy",  32'(bus.o_rs_busy[0]), 32'h1);
    chk("iss_stall", 32'(bus.o_stall), 32'h1);
    rs(0, 5, 1'b0);
    #1;
    chk("iss_noen_stall", 32'(bus.o_stall), 32'h0);
    chk("iss_noen_busy",  32'(bus.o_rs_busy[0]), 32'h1);
    tick();
    idle();
    wb(1, 5, 16'h00AB);
    rs(0, 5, 1'b1);
    #1;
    chk("wb_busy",  32'(bus.o_rs_busy[0]), 32'h0);
    chk("wb_stall", 32'(bus.o_stall), 32'h0);
    chk("wb_data",  32'(bus.o_rs_data[15:0]), 32'h00AB);
    tick();
    idle();
    rs(0, 5, 1'b1);
    #1;
    chk("wb_cnt0",   32'(bus.o_rs_busy[0]), 32'h0);
    chk("wb_stored", 32'(bus.o_rs_data[15:0]), 32'h00AB);
    chk("wb_unf",    32'(bus.o_unf), 32'h0);

    // Saturation on r2, then underflow.
    idle();
    iss(0, 2);
    iss(1, 2);
    tick();
    idle();
    iss(0, 2);
    tick();
    idle();
    rs(0, 2, 1'b1);
    #1;
    chk("sat3_busy", 32'(bus.o_rs_busy[0]), 32'h1);
    chk("sat3_ovf",  32'(bus.o_ovf), 32'h0);
    iss(0, 2);
    tick();
    idle();
    #1;
    chk("sat4_ovf", 32'(bus.o_ovf), 32'h1);
    wb(0, 2, 16'h0011);
    wb(1, 2, 16'h0012);
    rs(0, 2, 1'b1);
    #1;
    chk("sat_held_busy", 32'(bus.o_rs_busy[0]), 32'h1);
    chk("sat_byp_data",  32'(bus.o_rs_data[15:0]), 32'h0012);
    tick();
    idle();
    wb(0, 2, 16'h0022);
    rs(0, 2, 1'b1);
    #1;
    chk("cnt1_wb_busy", 32'(bus.o_rs_busy[0]), 32'h0);
    tick();
    idle();
    #1;
    chk("cnt0_unf", 32'(bus.o_unf), 32'h0);
    wb(0, 2, 16'h0033);
    tick();
    idle();
    #1;
    chk("unf_set",  32'(bus.o_unf), 32'h1);
    chk("ovf_kept", 32'(bus.o_ovf), 32'h1);

    // Same-cycle issue and writeback on r1.
    idle();
    iss(0, 1);
    tick();
    idle();
    wb(0, 1, 16'h0101);
    iss(1, 1);
    rs(1, 1, 1'b1);
    #1;
    chk("iw_busy",  32'(bus.o_rs_busy[1]), 32'h0);
    chk("iw_data",  32'(bus.o_rs_data[31:16]), 32'h0101);
    chk("iw_stall", 32'(bus.o_stall), 32'h0);
    tick();
    idle();
    rs(1, 1, 1'b1);
    #1;
    chk("iw_next_busy", 32'(bus.o_rs_busy[1]), 32'h1);

    // Flush with gwe low (no effect), then with gwe high.
    idle();
    iss(0, 4);
    iss(1, 4);
    tick();
    idle();
    bus.gwe     = 1'b0;
    bus.i_flush = 1'b1;
    iss(0, 4);
    wb(1, 7, 16'h7777);
    rs(0, 4, 1'b1);
    rt(0, 7, 1'b1);
    #1;
    chk("gwe0_stall", 32'(bus.o_stall), 32'h1);
    chk("gwe0_byp",   32'(bus.o_rt_data[15:0]), 32'h7777);
    tick();
    idle();
    rs(0, 4, 1'b1);
    rt(0, 7, 1'b1);
    rs(1, 1, 1'b1);
    #1;
    chk("gwe0_r4_busy", 32'(bus.o_rs_busy[0]), 32'h1);
    chk("gwe0_r7_data", 32'(bus.o_rt_data[15:0]), 32'h0);
    chk("gwe0_r1_busy", 32'(bus.o_rs_busy[1]), 32'h1);
    bus.i_flush = 1'b1;
    iss(0, 4);
    wb(1, 7, 16'h7777);
    tick();
    idle();
    rs(0, 4, 1'b1);
    rt(0, 7, 1'b1);
    rs(1, 1, 1'b1);
    #1;
    chk("fl_r4_busy", 32'(bus.o_rs_busy[0]), 32'h0);
    chk("fl_r1_busy", 32'(bus.o_rs_busy[1]), 32'h0);
    chk("fl_r7_data", 32'(bus.o_rt_data[15:0]), 32'h7777);
    chk("fl_stall",   32'(bus.o_stall), 32'h0);
    chk("fl_ovf",     32'(bus.o_ovf), 32'h1);
    chk("fl_unf",     32'(bus.o_unf), 32'h1);

    // Asynchronous reset mid-cycle with r6 pending.
    idle();
    wb(0, 6, 16'hBEEF);
    tick();
    idle();
    iss(0, 6);
    iss(1, 6);
    tick();
    idle();
    rs(0, 6, 1'b1);
    #1;
    chk("pre_rst_busy", 32'(bus.o_rs_busy[0]), 32'h1);
    chk("pre_rst_data", 32'(bus.o_rs_data[15:0]), 32'hBEEF);
    wb(1, 0, 16'h5A5A);
    rt(1, 0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_r6_data", 32'(bus.o_rs_data[15:0]), 32'h0);
    chk("arst_r6_busy", 32'(bus.o_rs_busy[0]), 32'h0);
    chk("arst_stall",   32'(bus.o_stall), 32'h0);
    chk("arst_ovf",     32'(bus.o_ovf), 32'h0);
    chk("arst_unf",     32'(bus.o_unf), 32'h0);
    chk("arst_byp",     32'(bus.o_rt_data[31:16]), 32'h5A5A);
    rst_n = 1'b1;
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lc4_regfile_sb.md
LC4_REGFILE_SB -- requirements
Module: lc4_regfile_sb

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- n  16  data width
- NREG  8  register count
- ABITS  3  register-select width; NREG SHALL equal 2**ABITS
- NPIPE  2  pipe count; each pipe has 2 read ports, 1 write port and 1 issue port
- CBITS  2  width of each per-register pending counter
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning. Vector fields are packed with pipe p at bits [p*W +: W].
- clk  in  1  the only clock; rising edge
- rst_n  in  1  reset, asynchronous, active-low
- gwe  in  1  global write enable; state changes only when high
- i_rs  in  NPIPE*ABITS  rs selects
- i_rt  in  NPIPE*ABITS  rt selects
- i_rs_en, i_rt_en  in  NPIPE  read-port valid; gates the stall contribution only
- o_rs_data, o_rt_data  out  NPIPE*n  read data
- o_rs_busy, o_rt_busy  out  NPIPE  operand still pending after this cycle's writebacks
- o_stall  out  1  OR of (busy AND en) over all read ports
- i_rd, i_wdata, i_rd_we  in  NPIPE*ABITS, NPIPE*n, NPIPE  writeback ports
- i_iss_rd, i_iss_we  in  NPIPE*ABITS, NPIPE  issue ports; mark a future producer of a register
- i_flush  in  1  synchronous clear of all pending counters
- o_ovf, o_unf  out  1  sticky counter overflow / underflow flags

Function
REQ-003 Data write: on a clk rise with gwe=1, every register targeted by at least one asserted i_rd_we SHALL load the i_wdata of the highest-index pipe targeting it.
REQ-004 Read bypass (combinational): each read port SHALL return the i_wdata of the highest-index pipe whose i_rd_we=1 and whose i_rd equals that port's select. If no such pipe exists, it SHALL return the stored value.
REQ-005 Per register r, let W(r) = number of pipes writing r this cycle and I(r) = number of pipes issuing to r this cycle.
REQ-006 Busy for a read port selecting r SHALL be cnt[r] > W(r).
REQ-007 o_stall SHALL be combinational and independent of gwe.
REQ-008 Counter update on a clk rise with gwe=1 and i_flush=0:
- next = cnt[r] - W(r) + I(r), computed at CBITS+log2(NPIPE)+1 bits, signed
- if next < 0: cnt[r] becomes 0 and o_unf sets
- if next > 2**CBITS-1: cnt[r] becomes 2**CBITS-1 and o_ovf sets
REQ-009 When issue and writeback hit the same register in the same cycle, both SHALL apply (net effect 0 for one of each).
REQ-010 i_flush=1 with gwe=1 SHALL zero all counters at the edge, overriding issue and writeback counter effects. Data writes SHALL still occur.
REQ-011 o_ovf and o_unf SHALL remain set until reset. They are not cleared by i_flush.
REQ-012 With gwe=0, no register, counter or flag SHALL change. Read data, busy and stall SHALL still be driven.
REQ-013 Writeback latency SHALL be 0 cycles to the read ports (bypass) and 1 edge to stored state.
REQ-014 Issue-to-busy latency SHALL be 1 edge.

Reset
REQ-015 rst_n=0 SHALL immediately, without a clock and regardless of gwe, set all registers to 0, all counters to 0, and o_ovf = o_unf = 0.
REQ-016 During reset, o_stall and all busy outputs SHALL be 0. Read data SHALL equal the bypass of any active writeback, else 0.
REQ-017 State SHALL update on the first clk rise after rst_n deasserts, if gwe=1.

Verification
REQ-018 The bench SHALL cover these scenarios (defaults n=16, NPIPE=2):
- Dual write, same register: pipe0 writes r3=0x1111 and pipe1 writes r3=0x2222 in the same cycle -> the same-cycle read of r3 returns 0x2222; after the edge r3 stays 0x2222.
- Issue then writeback: issue r5 on pipe0; next cycle read r5 with rs_en=1 -> busy=1, o_stall=1. Writeback r5=0x00AB the following cycle -> busy=0, stall=0, data 0x00AB in the same cycle; cnt[r5]=0 after the edge.
- Three issues to r2 with no writeback -> cnt=3, o_ovf=0. A 4th issue -> cnt stays 3, o_ovf=1 until reset. Writeback r2 with no issue at cnt=0 -> o_unf=1.
- Simultaneous issue and writeback: cnt[r1]=1, pipe0 writes r1 while pipe1 issues r1 -> busy=0 in that cycle, cnt[r1]=1 after the edge, busy=1 the next cycle.
- Flush: with cnt[r4]=2 and i_flush=1 plus an issue to r4 -> all counters 0 after the edge and r4 not busy. With gwe=0, the same stimulus changes nothing.
- Asynchronous reset between clock edges with r6=0xBEEF and cnt[r6]=2 -> r6 reads 0 and busy=0 immediately; o_ovf and o_unf cleared.
